// File: rtl/obj_ram_arbiter.sv
// Arbiter/sequencer for the single-port object RAM: renderer has fixed priority,
// the two rope controllers alternate round-robin and may lock the RAM across a read-modify-write.
module obj_ram_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [2:0]          lock,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    output logic [2:0]          ack,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W-1:0]   ram_data,
    output logic                ram_wren,
    input  logic [DATA_W-1:0]   ram_q,
    output logic                busy,
    output logic                lock_timeout
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [1:0]        owner;
    logic [1:0]        lock_id;
    logic [1:0]        rr_last;
    logic              lock_valid;
    logic [CNT_W-1:0]  lock_cnt;

    logic [2:0]        cand;
    logic              win_valid;
    logic [1:0]        win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    always_comb begin
        cand = req;
        if (lock_valid)
            cand = req & (3'b001 << lock_id);
        win_valid = |cand;
        win = 2'd0;
        if (cand[0])
            win = 2'd0;
        else if (cand[1] && cand[2])
            win = (rr_last == 2'd1) ? 2'd2 : 2'd1;
        else if (cand[2])
            win = 2'd2;
        else if (cand[1])
            win = 2'd1;

        case (win)
            2'd1: begin
                win_addr  = addr[ADDR_W +: ADDR_W];
                win_wdata = wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                win_addr  = addr[2*ADDR_W +: ADDR_W];
                win_wdata = wdata[2*DATA_W +: DATA_W];
            end
            default: begin
                win_addr  = addr[0 +: ADDR_W];
                win_wdata = wdata[0 +: DATA_W];
            end
        endcase
        win_we = (win != 2'd0) && we[win];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            owner        <= 2'd0;
            lock_id      <= 2'd0;
            rr_last      <= 2'd2;
            lock_valid   <= 1'b0;
            lock_cnt     <= '0;
            ack          <= '0;
            rdata        <= '0;
            ram_address  <= '0;
            ram_data     <= '0;
            ram_wren     <= 1'b0;
            busy         <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            ack          <= '0;
            ram_wren     <= 1'b0;
            lock_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (lock_valid) begin
                        if (!lock[lock_id]) begin
                            lock_valid <= 1'b0;
                            lock_cnt   <= '0;
                        end else if (!req[lock_id]) begin
                            if (lock_cnt == CNT_LAST) begin
                                lock_valid   <= 1'b0;
                                lock_timeout <= 1'b1;
                                lock_cnt     <= '0;
                            end else begin
                                lock_cnt <= lock_cnt + 1'b1;
                            end
                        end
                    end
                    if (win_valid) begin
                        owner       <= win;
                        ram_address <= win_addr;
                        ram_data    <= win_wdata;
                        ram_wren    <= win_we;
                        // A write completes in S_ACCESS, so its ack rises together with ram_wren.
                        if (win_we)
                            ack <= 3'b001 << win;
                        lock_cnt    <= '0;
                        busy        <= 1'b1;
                        state       <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (ram_wren) begin
                        rr_last <= owner;
                        if (lock[owner]) begin
                            lock_valid <= 1'b1;
                            lock_id    <= owner;
                            lock_cnt   <= '0;
                        end
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    rdata <= ram_q;
                    ack   <= 3'b001 << owner;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (owner != 2'd0) begin
                        rr_last <= owner;
                        if (lock[owner]) begin
                            lock_valid <= 1'b1;
                            lock_id    <= owner;
                            lock_cnt   <= '0;
                        end
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obj_ram_arbiter.sv
// Randomized bench for obj_ram_arbiter: transaction-level scheduler model predicts
// acks, busy, RAM strobes, read data and lock timeouts cycle by cycle.
module tb_obj_ram_arbiter;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 16;
    localparam int NCYC     = 4096;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [2:0]          req_r, we_r, lock_r;
    logic [3*ADDR_W-1:0] addr_r;
    logic [3*DATA_W-1:0] wdata_r;
    logic [2:0]          ack;
    logic [DATA_W-1:0]   rdata, ram_data, ram_q;
    logic [ADDR_W-1:0]   ram_address;
    logic                ram_wren, busy, lock_timeout;

    obj_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clock(clock), .reset(reset), .req(req_r), .we(we_r), .lock(lock_r),
        .addr(addr_r), .wdata(wdata_r), .ack(ack), .rdata(rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q), .busy(busy), .lock_timeout(lock_timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] init_word(int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_1103);
    endfunction

    // RAM: registered address, unregistered q
    logic [DATA_W-1:0] mem [16];
    logic [ADDR_W-1:0] mem_a;
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            mem_a <= '0;
        end else begin
            if (ram_wren) mem[ram_address] <= ram_data;
            mem_a <= ram_address;
        end
    end
    assign ram_q = mem[mem_a];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    bit [2:0]        e_ack  [NCYC];
    bit              e_busy [NCYC];
    bit              e_wren [NCYC];
    bit              e_to   [NCYC];
    bit              e_rdv  [NCYC];
    bit [ADDR_W-1:0] e_addr [NCYC];
    bit [DATA_W-1:0] e_wdat [NCYC];
    bit [DATA_W-1:0] e_rdat [NCYC];

    int                m_free, m_own, m_cnt, m_rr;
    bit                m_lock;
    logic [DATA_W-1:0] ref_mem [16];
    bit                ghost [3];

    task automatic model_reset();
        m_lock = 0; m_cnt = 0; m_own = 1; m_rr = 2; m_free = cyc + 1;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 3; i++) ghost[i] = 0;
    endtask

    // One idle decision point of the arbiter; schedules the whole transaction ahead.
    task automatic model_step(input int e);
        logic [2:0]        cand;
        int                w, other;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        if (e < m_free) return;
        cand = m_lock ? (req_r & (3'b001 << m_own)) : req_r;
        if (m_lock) begin
            if (!lock_r[m_own]) begin
                m_lock = 0; m_cnt = 0;
            end else if (!req_r[m_own]) begin
                m_cnt++;
                if (m_cnt == LOCK_MAX) begin
                    m_lock = 0; m_cnt = 0; e_to[e] = 1;
                end
            end
        end
        other = 3 - m_rr;
        w = -1;
        if (cand[0]) w = 0;
        else if (cand[other]) w = other;
        else if (cand[m_rr]) w = m_rr;
        if (w < 0) return;
        m_cnt = 0;
        a = addr_r[w*ADDR_W +: ADDR_W];
        d = wdata_r[w*DATA_W +: DATA_W];
        if (w != 0 && we_r[w]) begin
            e_ack[e] = 3'(1 << w); e_wren[e] = 1; e_busy[e] = 1;
            e_addr[e] = a; e_wdat[e] = d;
            ref_mem[a] = d;
            m_free = e + 2;
        end else begin
            for (int k = 0; k < 3; k++) e_busy[e+k] = 1;
            e_ack[e+2] = 3'(1 << w); e_rdv[e+2] = 1; e_rdat[e+2] = ref_mem[a];
            m_free = e + 4;
        end
        if (w != 0) begin
            m_rr = w;
            if (lock_r[w]) begin
                m_lock = 1; m_own = w; m_cnt = 0;
            end
        end
    endtask

    function automatic int rate(input int mode, input int i);
        case (mode)
            0:       return (i == 0) ? 30 : 40;
            1:       return (i == 0) ? 0  : 80;
            2:       return (i == 0) ? 50 : 30;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input int mode);
        bit done;
        for (int i = 0; i < 3; i++) begin
            done = e_ack[cyc-1][i];
            if ((e_to[cyc] || mode == 3) && ghost[i]) begin
                ghost[i] = 0; lock_r[i] = 1'b0;
            end
            if (done) begin
                req_r[i] = 1'b0;
                if (mode == 2 && i != 0 && lock_r[i]) begin
                    case ($urandom_range(0, 2))
                        0:       ghost[i] = 1;
                        1:       ;
                        default: lock_r[i] = 1'b0;
                    endcase
                end else if (i != 0) begin
                    lock_r[i] = 1'b0;
                end
            end
            if (mode == 3 && !req_r[i] && i != 0) lock_r[i] = 1'b0;
            if (!req_r[i] && !ghost[i] && $urandom_range(0, 99) < rate(mode, i)) begin
                req_r[i] = 1'b1;
                addr_r[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom_range(0, 15));
                wdata_r[i*DATA_W +: DATA_W] = $urandom();
                if (i == 0) begin
                    we_r[0]   = ($urandom_range(0, 1) == 1);
                    lock_r[0] = ($urandom_range(0, 1) == 1);
                end else begin
                    we_r[i]   = (mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
                    lock_r[i] = (mode == 2) && ($urandom_range(0, 2) == 0);
                end
            end
        end
    endtask

    task automatic compare();
        check("ack", DATA_W'(ack), DATA_W'(e_ack[cyc]));
        check("busy", DATA_W'(busy), DATA_W'(e_busy[cyc]));
        check("ram_wren", DATA_W'(ram_wren), DATA_W'(e_wren[cyc]));
        check("lock_timeout", DATA_W'(lock_timeout), DATA_W'(e_to[cyc]));
        if (e_rdv[cyc]) check("rdata", rdata, e_rdat[cyc]);
        if (e_wren[cyc]) begin
            check("ram_address", DATA_W'(ram_address), DATA_W'(e_addr[cyc]));
            check("ram_data", ram_data, e_wdat[cyc]);
        end
    endtask

    task automatic run_cycles(input int n, input int mode);
        repeat (n) begin
            @(posedge clock);
            cyc++;
            model_step(cyc);
            #1;
            drive(mode);
            @(negedge clock);
            compare();
        end
    endtask

    initial begin
        req_r = '0; we_r = '0; lock_r = '0; addr_r = '0; wdata_r = '0;
        repeat (2) begin
            @(posedge clock);
            cyc++;
        end
        @(negedge clock);
        check("rst_ack", DATA_W'(ack), '0);
        check("rst_busy", DATA_W'(busy), '0);
        check("rst_wren", DATA_W'(ram_wren), '0);
        check("rst_timeout", DATA_W'(lock_timeout), '0);
        check("rst_rdata", rdata, '0);
        check("rst_ram_address", DATA_W'(ram_address), '0);
        check("rst_ram_data", ram_data, '0);
        reset = 1'b0;
        model_reset();

        run_cycles(600, 0);
        run_cycles(300, 1);
        run_cycles(900, 2);
        run_cycles(40, 3);

        // Reset asserted while a rope write sits in S_ACCESS; data equals the current word.
        req_r = 3'b010; we_r = 3'b010; lock_r = 3'b000;
        addr_r[ADDR_W +: ADDR_W]  = ADDR_W'(7);
        wdata_r[DATA_W +: DATA_W] = ref_mem[7];
        @(posedge clock);
        cyc++;
        #1;
        check("mid_wren_before", DATA_W'(ram_wren), DATA_W'(1));
        check("mid_busy_before", DATA_W'(busy), DATA_W'(1));
        check("mid_ack_before", DATA_W'(ack), DATA_W'(3'b010));
        reset = 1'b1;
        #1;
        check("mid_rst_wren", DATA_W'(ram_wren), '0);
        check("mid_rst_ack", DATA_W'(ack), '0);
        check("mid_rst_busy", DATA_W'(busy), '0);
        check("mid_rst_timeout", DATA_W'(lock_timeout), '0);
        req_r = '0; we_r = '0;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        req_r = 3'b110; we_r = 3'b000; lock_r = 3'b000;
        addr_r[ADDR_W +: ADDR_W]   = ADDR_W'($urandom_range(0, 15));
        addr_r[2*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
        run_cycles(300, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
